exc_irq_controller: RTL

//  Multi-channel exception/interrupt controller for the single-cycle LEGv8 core; registered successor to the combinational

---
 rtl/exc_irq_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/exc_irq_controller.sv
// Registered exception/interrupt controller: latches IRQ and illegal-instruction causes, arbitrates, handshakes.
// Optional feature macro IRQ_MASK_EN adds a per-channel mask register (mask_we / mask_wdata ports).
module exc_irq_controller #(
    parameter int N_IRQ     = 4,
    parameter int ESTATUS_W = 4,
    parameter int ID_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     ext_irq,
    input  logic                 not_an_instr,
    input  logic                 eret,
    input  logic                 exc_ack,
`ifdef IRQ_MASK_EN
    input  logic                 mask_we,
    input  logic [N_IRQ-1:0]     mask_wdata,
`endif
    output logic                 exc,
    output logic [ESTATUS_W-1:0] estatus,
    output logic [ID_W-1:0]      irq_id,
    output logic [N_IRQ-1:0]     ext_iack,
    output logic                 in_handler,
    output logic                 double_fault
);

    localparam logic [ESTATUS_W-1:0] CAUSE_NONE    = ESTATUS_W'(0);
    localparam logic [ESTATUS_W-1:0] CAUSE_EXT_IRQ = ESTATUS_W'(1);
    localparam logic [ESTATUS_W-1:0] CAUSE_ILLEGAL = ESTATUS_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HANDLER
    } state_t;

    state_t           state;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] pending_eff;
    logic [N_IRQ-1:0] pending_masked;
    logic [N_IRQ-1:0] pending_clr;
    logic [N_IRQ-1:0] iack_onehot;

    // Lowest set index wins: channel 0 has the highest priority.
    function automatic logic [ID_W-1:0] lowest_index(input logic [N_IRQ-1:0] v);
        lowest_index = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_index = ID_W'(i);
        end
    endfunction

`ifdef IRQ_MASK_EN
    logic [N_IRQ-1:0] mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '1;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end
`endif

    // A request seen this cycle counts immediately, so exc follows the cause with one cycle of latency.
    assign pending_eff = pending | ext_irq;
    assign iack_onehot = N_IRQ'(1) << irq_id;

`ifdef IRQ_MASK_EN
    assign pending_masked = pending_eff & mask;
`else
    assign pending_masked = pending_eff;
`endif

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pending_clr = '0;
        if (state == REQ && exc_ack && estatus == CAUSE_EXT_IRQ) begin
            pending_clr = iack_onehot;
        end
    end

    // Clear beats set on the ack edge; a level still high re-sets pending on the next edge.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | ext_irq) & ~pending_clr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            exc          <= 1'b0;
            estatus      <= CAUSE_NONE;
            irq_id       <= '0;
            ext_iack     <= '0;
            in_handler   <= 1'b0;
            double_fault <= 1'b0;
        end else begin
            ext_iack <= '0;
            unique case (state)
                IDLE: begin
                    if (|pending_masked) begin
                        state   <= REQ;
                        exc     <= 1'b1;
                        estatus <= CAUSE_EXT_IRQ;
                        irq_id  <= lowest_index(pending_masked);
                    end else if (not_an_instr) begin
                        state   <= REQ;
                        exc     <= 1'b1;
                        estatus <= CAUSE_ILLEGAL;
                        irq_id  <= '0;
                    end
                end
                REQ: begin
                    if (exc_ack) begin
                        state      <= HANDLER;
                        exc        <= 1'b0;
                        in_handler <= 1'b1;
                        if (estatus == CAUSE_EXT_IRQ) begin
                            ext_iack <= iack_onehot;
                        end
                    end
                end
                HANDLER: begin
                    if (not_an_instr) begin
                        double_fault <= 1'b1;
                    end
                    if (eret) begin
                        state      <= IDLE;
                        estatus    <= CAUSE_NONE;
                        irq_id     <= '0;
                        in_handler <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
